// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter width.
package bsa_pkg;

    // Operation phases: waiting for operands, shifting bits, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest legal operand width. The bit counter must be able to count
    // up to that width.
    localparam int MAX_WIDTH = 32;

    // Bit counter width, sized for the widest legal operand.
    localparam int CNT_W = $clog2(MAX_WIDTH + 1);

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the only arithmetic in the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in one bit per
// clock, LSB first. It uses a valid/ready start handshake and a valid/ready
// result handshake.
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic [WIDTH-1:0]   sum_sh_next;
    logic               carry;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               fa_sum;
    logic               fa_carry;
    logic               last_bit;

    // The single per-bit adder works on the operand LSBs and the running carry.
    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Each new sum bit enters at the MSB. After WIDTH shifts, bit 0 of the
    // result has reached the LSB.
    generate
        if (WIDTH > 1) begin : g_wide
            assign sum_sh_next = {fa_sum, sum_sh[WIDTH-1:1]};
        end else begin : g_narrow
            assign sum_sh_next = fa_sum;
        end
    endgenerate

    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, count WIDTH bits in RUN, wait for the consumer in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_valid) state_next = RUN;
            RUN:     if (last_bit)    state_next = DONE;
            DONE:    if (done_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, then shift one bit per RUN cycle.
    // The visible result registers update only on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_sh_next;
                    carry  <= fa_carry;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum_q  <= sum_sh_next;
                        cout_q <= fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=1 instances).
module tb_bit_serial_adder;

    logic       clk;
    logic       rst;

    logic       start_valid;
    logic       start_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       done_valid;
    logic       done_ready;

    logic       start_valid1;
    logic       start_ready1;
    logic       a1;
    logic       b1;
    logic       cin1;
    logic       sum1;
    logic       cout1;
    logic       done_valid1;
    logic       done_ready1;

    int checks;
    int failures;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sum         (sum),
        .cout        (cout),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid1),
        .start_ready (start_ready1),
        .a           (a1),
        .b           (b1),
        .cin         (cin1),
        .sum         (sum1),
        .cout        (cout1),
        .done_valid  (done_valid1),
        .done_ready  (done_ready1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts every comparison and reports each mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Presents operands for one cycle on the 8-bit instance, then scrambles them.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        @(negedge clk);
        checkOutput("ready_before_accept", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        a   = av;
        b   = bv;
        cin = cv;
        @(negedge clk);
        start_valid = 1'b0;
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
    endtask

    // Counts falling edges until done_valid rises, bounded.
    task automatic waitDone(output int lat);
        lat = 0;
        while (!done_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Releases the result and checks the return to IDLE.
    task automatic releaseResult(input string tag);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        checkOutput({tag, "_done_low"}, 32'(done_valid), 32'd0);
        checkOutput({tag, "_ready_high"}, 32'(start_ready), 32'd1);
    endtask

    // Runs one full 8-bit operation and checks latency and result.
    task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic [7:0] es, input logic ec);
        int lat;
        applyStimulus(av, bv, cv);
        waitDone(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd8);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(es));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(ec));
        releaseResult(tag);
    endtask

    initial begin
        int lat;
        logic [1:0] exp2;
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        start_valid  = 1'b0;
        a            = '0;
        b            = '0;
        cin          = 1'b0;
        done_ready   = 1'b0;
        start_valid1 = 1'b0;
        a1           = 1'b0;
        b1           = 1'b0;
        cin1         = 1'b0;
        done_ready1  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(start_ready), 32'd1);
        checkOutput("rst_done", 32'(done_valid), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        runOp("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        runOp("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        runOp("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Result holds in IDLE until the next accept.
        @(negedge clk);
        checkOutput("idle_hold_sum", 32'(sum), 32'hFF);
        checkOutput("idle_hold_cout", 32'(cout), 32'd1);

        // Reset in the third RUN cycle clears outputs without a clock edge.
        applyStimulus(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_done", 32'(done_valid), 32'd0);
        checkOutput("abort_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        runOp("after_rst", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // Consumer stalls for five cycles; result must stay stable.
        applyStimulus(8'h5A, 8'h3C, 1'b0);
        waitDone(lat);
        checkOutput("stall_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_sum", 32'(sum), 32'h96);
            checkOutput("stall_cout", 32'(cout), 32'd0);
            checkOutput("stall_done", 32'(done_valid), 32'd1);
            @(negedge clk);
        end
        releaseResult("stall");

        // A start pulse during RUN is neither sampled nor queued.
        applyStimulus(8'h23, 8'h45, 1'b0);
        repeat (2) @(negedge clk);
        start_valid = 1'b1;
        a = 8'h11;
        b = 8'h11;
        @(negedge clk);
        start_valid = 1'b0;
        waitDone(lat);
        checkOutput("pulse_latency", 32'(lat), 32'd5);
        checkOutput("pulse_sum", 32'(sum), 32'h68);
        checkOutput("pulse_cout", 32'(cout), 32'd0);
        releaseResult("pulse");
        @(negedge clk);
        checkOutput("pulse_not_queued", 32'(start_ready), 32'd1);

        // WIDTH=1 instance behaves as a registered full adder.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start_valid1 = 1'b1;
            a1   = i[0];
            b1   = i[1];
            cin1 = i[2];
            exp2 = 2'(i[0]) + 2'(i[1]) + 2'(i[2]);
            @(negedge clk);
            start_valid1 = 1'b0;
            a1   = ~a1;
            b1   = ~b1;
            cin1 = ~cin1;
            lat = 0;
            while (!done_valid1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            checkOutput("w1_latency", 32'(lat), 32'd1);
            checkOutput("w1_result", 32'({cout1, sum1}), 32'(exp2));
            done_ready1 = 1'b1;
            @(negedge clk);
            done_ready1 = 1'b0;
            checkOutput("w1_ready", 32'(start_ready1), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
